// File: rtl/sim_settle_scheduler.sv
// Half-cycle sequencer for the switch-level node network: toggles phi_o, lets nodes settle, counts steps.
// Define SIM_SETTLE_STATS_EN to build the worst-case settle statistic on max_settle_o.
module sim_settle_scheduler #(
   parameter int MIN_QUIET  = 4,
   parameter int MAX_SETTLE = 255,
   parameter int STEP_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [STEP_W-1:0] n_steps_i,
   input  logic              abort_i,
   input  logic              node_activity_i,
   output logic              node_en_o,
   output logic              phi_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic [31:0]       half_cycles_o,
   output logic [7:0]        max_settle_o
);

   // state  | meaning
   // IDLE   | waiting for start_i
   // DRIVE  | toggle phi_o, reload quiet and settle timers
   // SETTLE | node integrators enabled, wait for quiet window or timeout
   // CHECK  | count the completed half-cycle, pick next step or finish
   // DONE   | one-cycle done_o pulse
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int TMR_W = (MAX_SETTLE > 1) ? $clog2(MAX_SETTLE) : 1;
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(MAX_SETTLE - 1);
   localparam logic [7:0]       QUIET_LOAD  = 8'(MIN_QUIET - 1);

   state_t            state_q, state_d;
   logic              phi_q, phi_d;
   logic              timeout_q, timeout_d;
   logic [STEP_W-1:0] steps_left_q, steps_left_d;
   logic [7:0]        quiet_tmr_q, quiet_tmr_d;
   logic [TMR_W-1:0]  settle_tmr_q, settle_tmr_d;
   logic [31:0]       half_cycles_q, half_cycles_d;
   logic              settled;
   logic              settle_tc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         phi_q         <= 1'b0;
         timeout_q     <= 1'b0;
         steps_left_q  <= '0;
         quiet_tmr_q   <= '0;
         settle_tmr_q  <= '0;
         half_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         phi_q         <= phi_d;
         timeout_q     <= timeout_d;
         steps_left_q  <= steps_left_d;
         quiet_tmr_q   <= quiet_tmr_d;
         settle_tmr_q  <= settle_tmr_d;
         half_cycles_q <= half_cycles_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      phi_d         = phi_q;
      timeout_d     = timeout_q;
      steps_left_d  = steps_left_q;
      quiet_tmr_d   = quiet_tmr_q;
      settle_tmr_d  = settle_tmr_q;
      half_cycles_d = half_cycles_q;
      settled       = 1'b0;
      settle_tc     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (n_steps_i != '0) begin
                  steps_left_d = n_steps_i;
                  timeout_d    = 1'b0;
                  state_d      = DRIVE;
               end else begin
                  state_d = DONE;
               end
            end
         end

         DRIVE: begin
            quiet_tmr_d  = QUIET_LOAD;
            settle_tmr_d = SETTLE_LOAD;
            // an abort here means the half-cycle never starts, so phi_o is left alone
            if (abort_i) begin
               state_d = DONE;
            end else begin
               phi_d   = ~phi_q;
               state_d = SETTLE;
            end
         end

         SETTLE: begin
            settled      = !node_activity_i && (quiet_tmr_q == '0);
            settle_tc    = (settle_tmr_q == '0);
            settle_tmr_d = settle_tc ? '0 : settle_tmr_q - 1'b1;
            if (node_activity_i)
               quiet_tmr_d = QUIET_LOAD;
            else if (quiet_tmr_q != '0)
               quiet_tmr_d = quiet_tmr_q - 1'b1;

            if (abort_i) begin
               state_d = DONE;
            end else if (settled) begin
               state_d = CHECK;
            end else if (settle_tc) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end

         CHECK: begin
            half_cycles_d = half_cycles_q + 32'd1;
            steps_left_d  = (steps_left_q == '0) ? '0 : steps_left_q - 1'b1;
            if (abort_i || steps_left_q <= STEP_W'(1))
               state_d = DONE;
            else
               state_d = DRIVE;
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   assign node_en_o     = (state_q == SETTLE);
   assign busy_o        = (state_q != IDLE);
   assign done_o        = (state_q == DONE);
   assign phi_o         = phi_q;
   assign timeout_o     = timeout_q;
   assign half_cycles_o = half_cycles_q;

`ifdef SIM_SETTLE_STATS_EN
   logic [31:0] settle_len;
   logic [7:0]  settle_len_q, settle_len_d;
   logic [7:0]  max_settle_q, max_settle_d;

   // elapsed SETTLE cycles is recovered from the down-counting timer
   always_comb begin
      settle_len   = 32'(MAX_SETTLE) - 32'(settle_tmr_q);
      settle_len_d = settle_len_q;
      max_settle_d = max_settle_q;
      if (state_q == SETTLE && settled)
         settle_len_d = (settle_len > 32'd255) ? 8'd255 : settle_len[7:0];
      if (state_q == CHECK && settle_len_q > max_settle_q)
         max_settle_d = settle_len_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         settle_len_q <= '0;
         max_settle_q <= '0;
      end else begin
         settle_len_q <= settle_len_d;
         max_settle_q <= max_settle_d;
      end
   end

   assign max_settle_o = max_settle_q;
`else
   assign max_settle_o = 8'd0;
`endif

endmodule

// File: doc/sim_settle_scheduler.md
Name: sim_settle_scheduler

Overview:
- Sequences the saturating switch-level node network one simulated half-cycle at a time.
- Per half-cycle: toggles the simulated chip clock pad (phi_o, fed to a pad_input model), then enables the node integrators. It waits until no node voltage has changed for MIN_QUIET consecutive cycles, then advances.
- The host requests N half-cycles and receives a done pulse, or a timeout if the network oscillates or fails to settle.

Parameters:
- MIN_QUIET, 4, consecutive activity-free cycles that define "settled"; legal range 1..255.
- MAX_SETTLE, 255, maximum SETTLE cycles per half-cycle before timeout; must be >= MIN_QUIET.
- STEP_W, 16, width of the half-cycle request count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start_i  in  1  run request; sampled only in IDLE.
- n_steps_i  in  STEP_W  half-cycles to run; latched on accepted start.
- abort_i  in  1  stop the current run at the next state boundary.
- node_activity_i  in  1  OR of all node "voltage changed this cycle" flags.
- node_en_o  out  1  enables node voltage update in the node bank.
- phi_o  out  1  simulated chip clock pad level.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse at end of run.
- timeout_o  out  1  sticky; set on settle timeout, cleared on next accepted start.
- half_cycles_o  out  32  total completed half-cycles since reset; wraps modulo 2^32.
- max_settle_o  out  8  worst-case settle cycles; feature-dependent.

Behaviour:
- Reset (asynchronous, active-low), all outputs 0:
  - state=IDLE; phi_o=0, node_en_o=0, busy_o=0, done_o=0, timeout_o=0.
  - half_cycles_o=0, steps_left=0, quiet_cnt=0, settle_cnt=0.
- IDLE:
  - start_i && n_steps_i!=0 -> latch steps_left=n_steps_i, clear timeout_o, go to DRIVE.
  - start_i && n_steps_i==0 -> go to DONE with no phi change.
  - start_i is ignored while busy.
- DRIVE (1 cycle):
  - phi_o <= ~phi_o; node_en_o=0; clear quiet_cnt and settle_cnt; go to SETTLE.
- SETTLE:
  - node_en_o=1; settle_cnt increments every cycle.
  - node_activity_i=1 -> quiet_cnt=0; otherwise quiet_cnt+1.
  - Settled = node_activity_i==0 && quiet_cnt==MIN_QUIET-1 -> go to CHECK.
  - Else settle_cnt==MAX_SETTLE-1 -> set timeout_o, go to DONE (run aborted; phi_o holds).
  - Settled and timeout in the same cycle -> settled wins.
- CHECK (1 cycle):
  - node_en_o=0; half_cycles_o+1; steps_left-1.
  - steps_left was 1 -> go to DONE; else go to DRIVE.
- DONE (1 cycle): done_o=1; go to IDLE.
- abort_i:
  - Sampled in DRIVE, SETTLE and CHECK; takes priority over every other transition, including timeout.
  - Next state is DONE, so node_en_o drops next cycle.
  - A half-cycle interrupted in SETTLE is not counted; phi_o keeps its current level.
- Latency, n=1, MIN_QUIET=4, no activity:
  - start in cycle 0 -> DRIVE cycle 1, SETTLE cycles 2-5, CHECK cycle 6, done_o in cycle 7.
  - Per half-cycle cost = 2 + settle cycles.
- reset_n asserted mid-run -> immediate return to reset values; phi_o returns to 0.
- All counters saturate or wrap as stated; steps_left never underflows.

Optional Feature:
- Macro: SIM_SETTLE_STATS_EN.
- Defined:
  - max_settle_o holds the largest settle_cnt seen at a settled exit from SETTLE since reset.
  - Saturates at 255; timed-out half-cycles are excluded.
  - Updated in the CHECK cycle.
- Not defined: max_settle_o tied to 0 and no statistics register is built.

Test Plan:
- Reset then start_i with n_steps_i=1, node_activity_i=0 -> done_o high exactly in cycle 7; phi_o=1; half_cycles_o=1; timeout_o=0.
- n_steps_i=4, node_activity_i high for the first 3 SETTLE cycles of each half-cycle -> each SETTLE lasts 7 cycles; phi_o ends at 0; half_cycles_o=4; max_settle_o=7 (stats on) or 0 (stats off).
- node_activity_i held high, MAX_SETTLE=16 -> timeout_o=1 after 16 SETTLE cycles, done_o the next cycle, half_cycles_o unchanged; next start clears timeout_o.
- start_i with n_steps_i=0 -> done_o one cycle after start, phi_o and half_cycles_o unchanged, busy_o high for 1 cycle.
- abort_i pulsed in the 2nd SETTLE cycle of step 2 of 5 -> node_en_o low next cycle, done_o the following cycle, half_cycles_o=1.
- reset_n pulsed low mid-SETTLE -> all outputs 0 asynchronously; a fresh start then behaves as in test 1.
